// File: rtl/xfer_pkg.sv
// Shared transfer-bus definitions: bus widths and the decode strobe bundle
// used by the transfer register, pointer register and pipeline decode.
package xfer_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef struct packed {
    logic l_pl;
    logic l_ph;
    logic l_px;
    logic a_pl;
    logic a_ph;
    logic a_px_addr;
    logic a_px_xfer;
    logic inc;
    logic dec;
  } strobe_t;

endpackage

// File: rtl/pointer_register_if.sv
// Bus and strobe bundle for the pointer register; slave is the register,
// master is whatever drives the strobes and reads the buses.
interface pointer_register_if;
  import xfer_pkg::*;

  logic [BYTE_W-1:0] main_bus_in;
  logic [BYTE_W-1:0] main_bus_out;
  logic              main_bus_oe;
  logic [WORD_W-1:0] bus_in;
  logic [WORD_W-1:0] bus_out;
  logic              bus_oe;
  logic [WORD_W-1:0] addr_out;
  logic              addr_oe;
  logic              l_pl;
  logic              l_ph;
  logic              l_px;
  logic              a_pl;
  logic              a_ph;
  logic              a_px_addr;
  logic              a_px_xfer;
  logic              inc;
  logic              dec;
  logic              wrap;
  logic              err;

  modport slave (
    input  main_bus_in, bus_in,
    input  l_pl, l_ph, l_px, a_pl, a_ph, a_px_addr, a_px_xfer, inc, dec,
    output main_bus_out, main_bus_oe, bus_out, bus_oe, addr_out, addr_oe,
    output wrap, err
  );

  modport master (
    output main_bus_in, bus_in,
    output l_pl, l_ph, l_px, a_pl, a_ph, a_px_addr, a_px_xfer, inc, dec,
    input  main_bus_out, main_bus_oe, bus_out, bus_oe, addr_out, addr_oe,
    input  wrap, err
  );

endinterface

// File: rtl/ptr_updown16.sv
// Pointer state: prioritised word/byte load, then +/-1 modify, with a
// registered one-cycle wrap flag for modifies that cross 0xFFFF/0x0000.
module ptr_updown16
  import xfer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l_px,
  input  logic              l_pl,
  input  logic              l_ph,
  input  logic              inc,
  input  logic              dec,
  input  logic [WORD_W-1:0] bus_in,
  input  logic [BYTE_W-1:0] main_bus_in,
  output logic [WORD_W-1:0] ptr,
  output logic              wrap
);

  logic [WORD_W-1:0] ptr_nxt;
  logic              wrap_nxt;

  always_comb begin
    ptr_nxt  = ptr;
    wrap_nxt = 1'b0;
    if (l_px) begin
      ptr_nxt = bus_in;
    end else if (l_pl || l_ph) begin
      if (l_pl) ptr_nxt[BYTE_W-1:0]      = main_bus_in;
      if (l_ph) ptr_nxt[WORD_W-1:BYTE_W] = main_bus_in;
    end else if (inc && !dec) begin
      ptr_nxt  = ptr + WORD_W'(1);
      wrap_nxt = (ptr == '1);
    end else if (dec && !inc) begin
      ptr_nxt  = ptr - WORD_W'(1);
      wrap_nxt = (ptr == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else begin
      ptr  <= ptr_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: rtl/pointer_register.sv
// 16-bit pointer register: state lives in ptr_updown16; this level gates the
// three bus drivers combinationally and keeps the sticky strobe-conflict flag.
module pointer_register
  import xfer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  pointer_register_if.slave   pif
);

  strobe_t           strb;
  logic [WORD_W-1:0] ptr;
  logic              wrap;
  logic              err;
  logic              byte_conflict;

  always_comb begin
    strb           = '0;
    strb.l_pl      = pif.l_pl;
    strb.l_ph      = pif.l_ph;
    strb.l_px      = pif.l_px;
    strb.a_pl      = pif.a_pl;
    strb.a_ph      = pif.a_ph;
    strb.a_px_addr = pif.a_px_addr;
    strb.a_px_xfer = pif.a_px_xfer;
    strb.inc       = pif.inc;
    strb.dec       = pif.dec;
  end

  ptr_updown16 u_ptr (
    .clk         (clk),
    .rst_n       (rst_n),
    .l_px        (strb.l_px),
    .l_pl        (strb.l_pl),
    .l_ph        (strb.l_ph),
    .inc         (strb.inc),
    .dec         (strb.dec),
    .bus_in      (pif.bus_in),
    .main_bus_in (pif.main_bus_in),
    .ptr         (ptr),
    .wrap        (wrap)
  );

  assign byte_conflict = strb.a_pl && strb.a_ph;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (byte_conflict) begin
      err <= 1'b1;
    end
  end

  // Drivers are released while reset is low, whatever the strobes say.
  always_comb begin
    pif.addr_oe      = rst_n && strb.a_px_addr;
    pif.bus_oe       = rst_n && strb.a_px_xfer;
    pif.main_bus_oe  = rst_n && (strb.a_pl ^ strb.a_ph);
    pif.addr_out     = pif.addr_oe ? ptr : '0;
    pif.bus_out      = pif.bus_oe  ? ptr : '0;
    pif.main_bus_out = '0;
    if (pif.main_bus_oe) begin
      pif.main_bus_out = strb.a_pl ? ptr[BYTE_W-1:0] : ptr[WORD_W-1:BYTE_W];
    end
  end

  assign pif.wrap = wrap;
  assign pif.err  = err;

endmodule

// File: tb/tb_pointer_register.sv
// Self-checking bench for pointer_register: directed scenarios plus a random
// strobe run against an arithmetic reference model of the pointer.
module tb_pointer_register;
  import xfer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pointer_register_if pif ();

  pointer_register dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  int errors = 0;
  int checks = 0;

  int   m_ptr;   // 0..65535
  logic m_wrap;
  logic m_err;

  task automatic idle();
    pif.l_pl = 0; pif.l_ph = 0; pif.l_px = 0;
    pif.a_pl = 0; pif.a_ph = 0; pif.a_px_addr = 0; pif.a_px_xfer = 0;
    pif.inc = 0; pif.dec = 0;
  endtask

  // Advance the model by the strobes currently applied, then clock the DUT.
  task automatic tick();
    if (!rst_n) begin
      m_ptr = 0; m_wrap = 0; m_err = 0;
    end else begin
      if (pif.a_pl && pif.a_ph) m_err = 1;
      m_wrap = 0;
      if (pif.l_px) m_ptr = int'(pif.bus_in);
      else if (pif.l_pl || pif.l_ph) begin
        if (pif.l_pl) m_ptr = (m_ptr / 256) * 256 + int'(pif.main_bus_in);
        if (pif.l_ph) m_ptr = int'(pif.main_bus_in) * 256 + (m_ptr % 256);
      end else if (pif.inc && !pif.dec) begin
        m_wrap = (m_ptr == 65535);
        m_ptr  = (m_ptr + 1) % 65536;
      end else if (pif.dec && !pif.inc) begin
        m_wrap = (m_ptr == 0);
        m_ptr  = (m_ptr + 65535) % 65536;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    pif.l_pl = 1; pif.l_ph = 1; pif.l_px = 1;
    pif.a_pl = 1; pif.a_ph = 1; pif.a_px_addr = 1; pif.a_px_xfer = 1;
    pif.inc = 1; pif.dec = 1;
    pif.bus_in = 16'h5A5A; pif.main_bus_in = 8'hC3;
    #1;
    checks++;
    if ({pif.addr_oe, pif.bus_oe, pif.main_bus_oe} !== 3'b000) begin
      errors++; $display("FAIL reset_oe: got %b expected 000", {pif.addr_oe, pif.bus_oe, pif.main_bus_oe});
    end
    tick(); tick();
    checks++;
    if ({pif.addr_oe, pif.bus_oe, pif.main_bus_oe} !== 3'b000) begin
      errors++; $display("FAIL reset_oe_held: got %b expected 000", {pif.addr_oe, pif.bus_oe, pif.main_bus_oe});
    end
    idle();
    rst_n = 1;
    pif.a_px_addr = 1;
    #1;
    checks++;
    if (pif.addr_out !== 16'h0000 || pif.addr_oe !== 1'b1) begin
      errors++; $display("FAIL reset_ptr: got %h oe=%b expected 0000 oe=1", pif.addr_out, pif.addr_oe);
    end
    checks++;
    if (pif.err !== 1'b0 || pif.wrap !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got err=%b wrap=%b expected 0 0", pif.err, pif.wrap);
    end
    idle();
  endtask

  task automatic test_load_assert();
    pif.l_px = 1; pif.bus_in = 16'hBEEF;
    pif.a_px_xfer = 1;
    #1;
    checks++;
    if (pif.bus_out !== 16'h0000) begin
      errors++; $display("FAIL load_old_value: got %h expected 0000", pif.bus_out);
    end
    tick();
    idle();
    pif.a_px_addr = 1; pif.a_pl = 1;
    #1;
    checks++;
    if (pif.addr_out !== 16'hBEEF || pif.addr_oe !== 1'b1) begin
      errors++; $display("FAIL load_addr: got %h oe=%b expected beef oe=1", pif.addr_out, pif.addr_oe);
    end
    checks++;
    if (pif.main_bus_out !== 8'hEF || pif.main_bus_oe !== 1'b1) begin
      errors++; $display("FAIL assert_low: got %h oe=%b expected ef oe=1", pif.main_bus_out, pif.main_bus_oe);
    end
    pif.a_pl = 0; pif.a_ph = 1; pif.a_px_xfer = 1;
    #1;
    checks++;
    if (pif.main_bus_out !== 8'hBE) begin
      errors++; $display("FAIL assert_high: got %h expected be", pif.main_bus_out);
    end
    checks++;
    if (pif.bus_out !== 16'hBEEF || pif.bus_oe !== 1'b1 || pif.addr_oe !== 1'b1) begin
      errors++; $display("FAIL assert_both_words: got %h oe=%b/%b expected beef 1/1", pif.bus_out, pif.bus_oe, pif.addr_oe);
    end
    idle();
    #1;
    checks++;
    if ({pif.addr_out, pif.bus_out, pif.main_bus_out} !== 40'h0) begin
      errors++; $display("FAIL idle_outputs: got %h expected 0", {pif.addr_out, pif.bus_out, pif.main_bus_out});
    end
  endtask

  task automatic test_byte_loads();
    pif.l_ph = 1; pif.main_bus_in = 8'h12; tick();
    pif.l_ph = 0; pif.l_pl = 1; pif.main_bus_in = 8'h34; tick();
    idle(); pif.a_px_xfer = 1; #1;
    checks++;
    if (pif.bus_out !== 16'h1234) begin
      errors++; $display("FAIL byte_loads: got %h expected 1234", pif.bus_out);
    end
    idle();
    pif.l_px = 1; pif.bus_in = 16'hAAAA; pif.l_pl = 1; pif.main_bus_in = 8'h55; pif.inc = 1;
    tick();
    idle(); pif.a_px_xfer = 1; #1;
    checks++;
    if (pif.bus_out !== 16'hAAAA || pif.wrap !== 1'b0) begin
      errors++; $display("FAIL load_priority: got %h wrap=%b expected aaaa wrap=0", pif.bus_out, pif.wrap);
    end
    idle();
    pif.l_pl = 1; pif.l_ph = 1; pif.main_bus_in = 8'h7E; tick();
    idle(); pif.a_px_xfer = 1; #1;
    checks++;
    if (pif.bus_out !== 16'h7E7E) begin
      errors++; $display("FAIL both_byte_load: got %h expected 7e7e", pif.bus_out);
    end
    idle();
  endtask

  task automatic test_wrap();
    logic [15:0] exp_p [5] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    logic        exp_w [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    pif.l_px = 1; pif.bus_in = 16'hFFFE; tick(); idle();
    for (int i = 0; i < 5; i++) begin
      idle();
      case (i)
        0, 1: pif.inc = 1;
        3:    pif.dec = 1;
        4:    begin pif.inc = 1; pif.dec = 1; end
        default: ;
      endcase
      tick();
      idle(); pif.a_px_addr = 1; #1;
      checks++;
      if (pif.addr_out !== exp_p[i] || pif.wrap !== exp_w[i]) begin
        errors++; $display("FAIL wrap_step%0d: got %h wrap=%b expected %h wrap=%b", i, pif.addr_out, pif.wrap, exp_p[i], exp_w[i]);
      end
    end
    idle();
  endtask

  task automatic test_conflict();
    pif.a_pl = 1; pif.a_ph = 1; #1;
    checks++;
    if (pif.main_bus_oe !== 1'b0 || pif.main_bus_out !== 8'h00 || pif.err !== 1'b0) begin
      errors++; $display("FAIL conflict_drive: got oe=%b out=%h err=%b expected 0 00 0", pif.main_bus_oe, pif.main_bus_out, pif.err);
    end
    tick(); idle();
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (pif.err !== 1'b1) begin
        errors++; $display("FAIL err_sticky%0d: got %b expected 1", i, pif.err);
      end
      tick();
    end
    rst_n = 0; tick(); rst_n = 1; #1;
    checks++;
    if (pif.err !== 1'b0) begin
      errors++; $display("FAIL err_clear: got %b expected 0", pif.err);
    end
  endtask

  task automatic test_reset_mid_run();
    pif.l_px = 1; pif.bus_in = 16'h0010; tick(); idle();
    pif.inc = 1;
    tick(); tick(); tick();
    pif.a_px_addr = 1; #1;
    checks++;
    if (pif.addr_out !== 16'h0013) begin
      errors++; $display("FAIL inc_run: got %h expected 0013", pif.addr_out);
    end
    rst_n = 0; tick(); tick();
    rst_n = 1; pif.inc = 0; #1;
    checks++;
    if (pif.addr_out !== 16'h0000 || pif.wrap !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run: got %h wrap=%b expected 0000 0", pif.addr_out, pif.wrap);
    end
    pif.inc = 1; tick(); pif.inc = 0; #1;
    checks++;
    if (pif.addr_out !== 16'h0001) begin
      errors++; $display("FAIL inc_after_reset: got %h expected 0001", pif.addr_out);
    end
    idle();
  endtask

  task automatic test_random();
    logic [15:0] e_word;
    logic [7:0]  e_byte;
    logic        e_moe;
    for (int n = 0; n < 600; n++) begin
      rst_n         = ($urandom_range(0, 59) != 0);
      pif.l_px      = ($urandom_range(0, 9) == 0);
      pif.l_pl      = ($urandom_range(0, 9) == 0);
      pif.l_ph      = ($urandom_range(0, 9) == 0);
      pif.inc       = ($urandom_range(0, 2) == 0);
      pif.dec       = ($urandom_range(0, 2) == 0);
      pif.a_pl      = ($urandom_range(0, 3) == 0);
      pif.a_ph      = ($urandom_range(0, 3) == 0);
      pif.a_px_addr = $urandom_range(0, 1);
      pif.a_px_xfer = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       pif.bus_in = 16'hFFFF;
        1:       pif.bus_in = 16'h0000;
        default: pif.bus_in = 16'($urandom);
      endcase
      pif.main_bus_in = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      #1;
      e_word = rst_n ? 16'(m_ptr) : 16'h0000;
      e_moe  = rst_n && (pif.a_pl != pif.a_ph);
      e_byte = !e_moe ? 8'h00 : (pif.a_pl ? 8'(m_ptr % 256) : 8'(m_ptr / 256));
      checks++;
      if (pif.addr_oe !== (rst_n && pif.a_px_addr) ||
          pif.addr_out !== (pif.a_px_addr ? e_word : 16'h0000)) begin
        errors++; $display("FAIL rand_addr n=%0d: got %h oe=%b expected %h", n, pif.addr_out, pif.addr_oe, e_word);
      end
      checks++;
      if (pif.bus_oe !== (rst_n && pif.a_px_xfer) ||
          pif.bus_out !== (pif.a_px_xfer ? e_word : 16'h0000)) begin
        errors++; $display("FAIL rand_xfer n=%0d: got %h oe=%b expected %h", n, pif.bus_out, pif.bus_oe, e_word);
      end
      checks++;
      if (pif.main_bus_oe !== e_moe || pif.main_bus_out !== e_byte) begin
        errors++; $display("FAIL rand_main n=%0d: got %h oe=%b expected %h oe=%b", n, pif.main_bus_out, pif.main_bus_oe, e_byte, e_moe);
      end
      checks++;
      if (pif.wrap !== m_wrap || pif.err !== m_err) begin
        errors++; $display("FAIL rand_flags n=%0d: got wrap=%b err=%b expected %b %b", n, pif.wrap, pif.err, m_wrap, m_err);
      end
      tick();
    end
    rst_n = 1;
    idle();
  endtask

  initial begin
    idle();
    pif.bus_in = '0;
    pif.main_bus_in = '0;
    rst_n = 0;
    @(negedge clk);
    test_reset();
    test_load_assert();
    test_byte_loads();
    test_wrap();
    test_conflict();
    test_reset_mid_run();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pointer_register.md
# pointer_register

A 16-bit pointer register on the transfer bus, consuming what the transfer register sources. It loads a full word from the transfer bus, or a byte at a time from the main bus. It drives its value back onto the address bus, the transfer bus, or the main bus one byte at a time. Post-increment and post-decrement let it serve as a stack or index pointer. It sits alongside the transfer register and PC on the transfer/address buses, with strobes from the pipeline decode stage.

## Interface
- `WORD_W`, 16: pointer/transfer/address bus width.
- `BYTE_W`, 8: main bus width.

- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `main_bus_in`  in  8  main bus read value.
- `main_bus_out`  out  8  byte driven to main bus.
- `main_bus_oe`  out  1  main bus drive enable.
- `bus_in`  in  16  transfer bus read value.
- `bus_out`  out  16  word driven to transfer bus.
- `bus_oe`  out  1  transfer bus drive enable.
- `addr_out`  out  16  word driven to address bus.
- `addr_oe`  out  1  address bus drive enable.
- `l_pl` / `l_ph`  in  1  load low/high byte from `main_bus_in`.
- `l_px`  in  1  load full word from `bus_in`.
- `a_pl` / `a_ph`  in  1  assert low/high byte onto main bus.
- `a_px_addr` / `a_px_xfer`  in  1  assert word onto address/transfer bus.
- `inc` / `dec`  in  1  post-increment/decrement by 1.
- `wrap`  out  1  one-cycle pulse: last modify wrapped.
- `err`  out  1  sticky strobe-conflict flag.
- All strobes are active-high.

## Operation
- State: `ptr[15:0]` and `err`, plus the registered `wrap`.
- Reset while `rst_n`=0 at an edge:
  - `ptr`=0x0000, `err`=0, `wrap`=0.
  - All `*_oe` are forced to 0 combinationally while `rst_n`=0, regardless of strobes.
- Update priority at each edge, highest first:
  1. `l_px`: `ptr` ← `bus_in`.
  2. `l_pl`/`l_ph`: replace the selected byte(s) with `main_bus_in`. Both set means both bytes take the same value.
  3. `inc` xor `dec`: `ptr` ← `ptr` ± 1, modulo 2^16.
  4. Otherwise hold.
- `inc` and `dec` together: no change, no `wrap`.
- A modify ignored because of a load produces no `wrap`.
- `wrap` is set for one cycle when an applied modify goes 0xFFFF→0x0000 (inc) or 0x0000→0xFFFF (dec). Otherwise it is 0.
- Asserts are combinational from the current `ptr`, matching 74HC245-style bus drivers:
  - `a_px_addr` → `addr_oe`=1, `addr_out`=`ptr`.
  - `a_px_xfer` → `bus_oe`=1, `bus_out`=`ptr`.
  - `a_pl` → `main_bus_oe`=1, `main_bus_out`=`ptr[7:0]`.
  - `a_ph` → `main_bus_oe`=1, `main_bus_out`=`ptr[15:8]`.
  - `a_px_addr` and `a_px_xfer` together are legal; both buses are driven.
- Conflict: `a_pl` and `a_ph` both high.
  - `main_bus_oe`=0 and `main_bus_out`=0x00 that cycle.
  - `err` is set at the edge and stays set until reset.
- Assert and load in the same cycle (e.g. `a_px_xfer`+`l_px`) are legal. Outputs show the old value; the new value is captured at the edge.
- When not driving, `*_out` = 0.

## Timing
- Load/modify latency 1: the value is visible on outputs in the cycle after the capturing edge.
- Assert latency 0: combinational from strobe to `oe`/`out`.
- `wrap` asserts in the cycle after the wrapping edge, for exactly one cycle.
- `err` asserts in the cycle after the conflict edge.
- Reset mid-sequence (e.g. during an inc run) is honoured at the next edge:
  - `ptr`=0 and `wrap`=0 from the following cycle.
  - Strobes are ignored while `rst_n`=0.
- Back-to-back `inc` every cycle advances `ptr` by 1 per cycle with no bubbles.

## Structure
- Shared package `xfer_pkg`:
  - `WORD_W` and `BYTE_W` constants.
  - A strobe-bundle typedef (`l_*`, `a_*`, `inc`, `dec`), so decode, transfer register and pointer register share one definition.
- One sub-module, `ptr_updown16`, is natural:
  - Contains the priority load/modify mux, the ±1 adder and wrap detection.
  - The top level holds the bus output gating and `err`.

## Test plan
- Reset with all strobes high → every `oe`=0 during reset; `ptr`=0x0000, `err`=0, `wrap`=0 after.
- `l_px` with `bus_in`=0xBEEF, then `a_px_addr` → `addr_out`=0xBEEF, `addr_oe`=1. Same cycle `a_pl` → `main_bus_out`=0xEF; `a_ph` → 0xBE.
- Load `l_ph`=0x12, then `l_pl`=0x34 → 0x1234. Then `l_px`(0xAAAA)+`l_pl`+`inc` in one cycle → 0xAAAA, `wrap`=0.
- Load 0xFFFE, `inc` ×2 → 0xFFFF, then 0x0000 with a one-cycle `wrap`. Then `dec` → 0xFFFF with `wrap`. Then `inc`+`dec` → unchanged.
- `a_pl`+`a_ph` together → `main_bus_oe`=0, `err`=1 next cycle; `err` holds through 10 idle cycles and clears only on reset.
- Assert `rst_n`=0 during an 8-cycle `inc` run starting at 0x0010 → `ptr`=0x0000 the cycle after the reset edge; `inc` is ignored while `rst_n`=0.
